// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative multiply/divide unit.
//   muldiv_op_e    - funct3 encodings of the eight M-extension operations
//   muldiv_state_e - control FSM states
//   is_signed_a/b  - operand signedness per operation
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit sharing one
// shift-add / restoring-subtract datapath across all eight operations.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   in_valid  in   op/a/b valid
//   in_ready  out  unit can accept an operation (registered)
//   op        in   funct3 operation code
//   a, b      in   rs1 / rs2 operands
//   out_valid out  result valid (registered)
//   out_ready in   consumer accepts result
//   result    out  operation result (registered)
//   zero      out  result == 0, only when MULDIV_ZERO_FLAG_EN is defined
//
// Optional feature macro: MULDIV_ZERO_FLAG_EN adds the registered zero flag.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// CALC  | WIDTH shift/add or shift/subtract iterations
// DONE  | first cycle: sign fix + result select; then hold until out_ready
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef MULDIV_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e    state_q, state_d;
    muldiv_op_e       op_q, op_d, op_in;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // hi: multiply high accumulator / division remainder
    // lo: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             neg_q, neg_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             sa, sb;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [2*WIDTH-1:0] full;
    logic [WIDTH-1:0] quo, rem;

    assign op_in = muldiv_op_e'(op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opb_d       = opb_q;
        neg_d       = neg_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sa          = is_signed_a(op_in) & a[WIDTH-1];
        sb          = is_signed_b(op_in) & b[WIDTH-1];
        sum         = '0;
        shifted     = '0;
        fits        = 1'b0;
        full        = '0;
        quo         = '0;
        rem         = '0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d       = op_in;
                    lo_d       = sa ? -a : a;
                    opb_d      = sb ? -b : b;
                    hi_d       = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    // remainder takes the dividend's sign, everything else sa^sb
                    neg_d      = (op_in == OP_REM || op_in == OP_REMU) ? sa : (sa ^ sb);
                    if (op_in[2] && b == '0) begin
                        lo_d    = '1;
                        hi_d    = a;
                        neg_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                                 a == MIN_NEG && b == '1) begin
                        lo_d    = a;
                        hi_d    = '0;
                        neg_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                if (!op_q[2]) begin
                    sum        = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
                    {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
                end else begin
                    shifted = {hi_q, lo_q[WIDTH-1]};
                    fits    = shifted >= {1'b0, opb_q};
                    hi_d    = fits ? WIDTH'(shifted - {1'b0, opb_q}) : shifted[WIDTH-1:0];
                    lo_d    = {lo_q[WIDTH-2:0], fits};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!out_valid_q) begin
                    full = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
                    quo  = neg_q ? -lo_q : lo_q;
                    rem  = neg_q ? -hi_q : hi_q;
                    case (op_q)
                        OP_MUL:                      result_d = full[WIDTH-1:0];
                        OP_MULH, OP_MULHSU, OP_MULHU: result_d = full[2*WIDTH-1:WIDTH];
                        OP_DIV, OP_DIVU:             result_d = quo;
                        default:                     result_d = rem;
                    endcase
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

`ifdef MULDIV_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b1;
        end else if (state_q == ST_DONE && !out_valid_q) begin
            zero_q <= (result_d == '0);
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
`ifdef MULDIV_ZERO_FLAG_EN
    logic        zero;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef MULDIV_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    task automatic check(input logic [31:0] observed, input logic [31:0] expected, input string tag);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Accept one operation, scramble inputs after the accept edge, and
    // return the number of edges until out_valid rises (0 means timeout).
    task automatic issue_and_wait(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input string tag, output int lat);
        @(negedge clk);
        check({31'd0, in_ready}, 32'd1, {tag, " in_ready before accept"});
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = ~o; a = $urandom; b = $urandom;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) lat = 0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] expected, input int exp_lat, input string tag);
        int lat;
        issue_and_wait(o, x, y, tag, lat);
        check(32'(lat), 32'(exp_lat), {tag, " latency"});
        check(result, expected, {tag, " result"});
`ifdef MULDIV_ZERO_FLAG_EN
        check({31'd0, zero}, {31'd0, expected == 32'd0}, {tag, " zero"});
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({31'd0, out_valid}, 32'd0, {tag, " out_valid after handshake"});
        check({31'd0, in_ready}, 32'd1, {tag, " in_ready after handshake"});
    endtask

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0; b = '0;
        #12;
        check({31'd0, in_ready}, 32'd1, "reset in_ready");
        check({31'd0, out_valid}, 32'd0, "reset out_valid");
        check(result, 32'd0, "reset result");
`ifdef MULDIV_ZERO_FLAG_EN
        check({31'd0, zero}, 32'd1, "reset zero");
`endif
        @(negedge clk);
        reset = 1'b0;

        do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33, "mulhsu");
        do_op(3'd5, 32'h0000_F0AE, 32'h0000_0FA1, 32'h0000_000F, 33, "divu");
        do_op(3'd7, 32'h0000_F0AE, 32'h0000_0FA1, 32'h0000_063F, 33, "remu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, "div");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, "rem");
        do_op(3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1,  "div by zero");
        do_op(3'd6, 32'd5,        32'd0,        32'd5,         1,  "rem by zero");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div overflow");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1, "rem overflow");

        // Backpressure: result held, in_ready low, a new request ignored.
        issue_and_wait(3'd5, 32'h0000_F0AE, 32'h0000_0FA1, "bp", lat);
        check(32'(lat), 32'd33, "bp latency");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
            @(posedge clk);
            #1;
            check(result, 32'h0000_000F, "bp result stable");
            check({31'd0, in_ready}, 32'd0, "bp in_ready low");
            check({31'd0, out_valid}, 32'd1, "bp out_valid held");
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({31'd0, in_ready}, 32'd1, "bp in_ready after release");
        check(result, 32'h0000_000F, "bp result after release");
        repeat (3) @(posedge clk);
        #1;
        check({31'd0, out_valid}, 32'd0, "bp ignored request not run");

        // Reset in the middle of CALC, at iteration 10.
        @(negedge clk);
        check({31'd0, in_ready}, 32'd1, "rst in_ready before accept");
        op = 3'd0; a = 32'd123; b = 32'd456; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check({31'd0, in_ready}, 32'd0, "rst in_ready busy");
        reset = 1'b1;
        #1;
        check({31'd0, in_ready}, 32'd1, "rst mid-calc in_ready");
        check({31'd0, out_valid}, 32'd0, "rst mid-calc out_valid");
        check(result, 32'd0, "rst mid-calc result");
`ifdef MULDIV_ZERO_FLAG_EN
        check({31'd0, zero}, 32'd1, "rst mid-calc zero");
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check({31'd0, out_valid}, 32'd0, "rst discarded op");

        do_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "mul after reset");
        do_op(3'd0, 32'd0, 32'd9, 32'd0,  33, "mul zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
